// File: rtl/fc_pkg.sv
// fc_pkg: shared types, widths, state encoding and saturation helper
// for the fully-connected layer sequencer.
//   DATA_W / PROD_W : operand and full-product widths
//   data_t / prod_t : signed operand and product types
//   state_t, ST_*   : controller state encoding
//   clog2_min1      : address width helper that never returns zero
//   sat16           : clamp a wide signed value into the 16-bit range
package fc_pkg;

   localparam int DATA_W = 16;
   localparam int PROD_W = 32;

   typedef logic signed [DATA_W-1:0] data_t;
   typedef logic signed [PROD_W-1:0] prod_t;

   typedef logic [2:0] state_t;
   localparam state_t ST_IDLE    = 3'd0;
   localparam state_t ST_L1      = 3'd1;
   localparam state_t ST_L1_TAIL = 3'd2;
   localparam state_t ST_L2      = 3'd3;
   localparam state_t ST_L2_TAIL = 3'd4;
   localparam state_t ST_DONE    = 3'd5;

   // A one-entry buffer still needs a one-bit address port.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic data_t sat16(input logic signed [63:0] v);
      if (v > 64'sd32767)
         return 16'sh7fff;
      else if (v < -64'sd32768)
         return 16'sh8000;
      else
         return v[DATA_W-1:0];
   endfunction

endpackage

// File: rtl/fc_mac_sat.sv
// fc_mac_sat: registered signed multiply-accumulate shared by both layers.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero the accumulator (wins over acc_en)
//   acc_en     : add a*b into the accumulator
//   a, b       : signed 16-bit operands
//   addend     : extra signed term folded into sat_sum only
//   sat_sum    : sat16(acc + a*b + addend), combinational
module fc_mac_sat
   import fc_pkg::*;
#(
   parameter int ACC_W = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              acc_en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] addend,
   output logic [DATA_W-1:0] sat_sum
);

   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] sum;
   prod_t                   prod;

   assign prod    = PROD_W'(signed'(a)) * PROD_W'(signed'(b));
   assign sum     = acc + ACC_W'(prod) + ACC_W'(signed'(addend));
   assign sat_sum = sat16(64'(sum));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (acc_en)
         acc <= acc + ACC_W'(prod);
   end

endmodule

// File: rtl/fc_layer_seq.sv
// fc_layer_seq: sequences one shared MAC over IP_LAYER hidden neurons of
// NUM_INP inputs each, then over the dense output neuron.
//   clk, rst            : clock, async active-low reset
//   start, bias         : begin an evaluation (IDLE only), dense bias
//   busy, done          : not-IDLE flag, one-cycle result pulse
//   out_data            : saturated signed result, held until next done
//   in_rd_en/in_addr    : input+weight buffer read (addr = j*NUM_INP+i)
//   in_data, wt_data    : buffer read data, valid the cycle after in_rd_en
//   dw_rd_en/dw_addr    : dense-weight buffer read (addr = j)
//   dw_data             : dense weight, valid the cycle after dw_rd_en
//
// state    | meaning
// ---------+--------------------------------------------------------
// IDLE     | waiting for start
// L1       | issuing input/weight reads for hidden neuron j
// L1_TAIL  | fold last product, store saturated hidden[j]
// L2       | issuing dense-weight reads, accumulating hidden*dw
// L2_TAIL  | fold last product and bias, register out_data
// DONE     | done pulse, back to IDLE
module fc_layer_seq
   import fc_pkg::*;
#(
   parameter  int IP_LAYER = 8,
   parameter  int NUM_INP  = 8,
   parameter  int ACC_W    = 40,
   localparam int AW       = clog2_min1(IP_LAYER * NUM_INP),
   localparam int JW       = clog2_min1(IP_LAYER)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] bias,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] out_data,
   output logic              in_rd_en,
   output logic [AW-1:0]     in_addr,
   input  logic [DATA_W-1:0] in_data,
   input  logic [DATA_W-1:0] wt_data,
   output logic              dw_rd_en,
   output logic [JW-1:0]     dw_addr,
   input  logic [DATA_W-1:0] dw_data
);

   localparam int IW = clog2_min1(NUM_INP);
   localparam logic [JW-1:0] J_LAST   = JW'(IP_LAYER - 1);
   localparam logic [IW-1:0] I_RELOAD = IW'(NUM_INP - 1);

   state_t            state;
   logic [JW-1:0]     j;
   logic [JW-1:0]     hid_idx;
   logic [IW-1:0]     i_cnt;
   logic [AW-1:0]     addr_q;
   logic              rd_vld;
   logic [DATA_W-1:0] bias_q;
   logic [DATA_W-1:0] hidden [IP_LAYER];

   logic              layer2;
   logic              mac_clr;
   logic              mac_en;
   logic [DATA_W-1:0] mac_a;
   logic [DATA_W-1:0] mac_b;
   logic [DATA_W-1:0] mac_add;
   logic [DATA_W-1:0] mac_sat;

   assign busy     = (state != ST_IDLE);
   assign in_rd_en = (state == ST_L1);
   assign dw_rd_en = (state == ST_L2);
   assign in_addr  = addr_q;
   assign dw_addr  = j;

   // Operand select follows the layer; read data lags its strobe by one
   // cycle, so rd_vld gates accumulation and the tails fold the last one.
   assign layer2  = (state == ST_L2) || (state == ST_L2_TAIL);
   assign mac_a   = layer2 ? dw_data : in_data;
   assign mac_b   = layer2 ? hidden[hid_idx] : wt_data;
   assign mac_add = (state == ST_L2_TAIL) ? bias_q : '0;
   assign mac_en  = rd_vld && ((state == ST_L1) || (state == ST_L2));
   assign mac_clr = ((state == ST_IDLE) && start) ||
                    (state == ST_L1_TAIL) || (state == ST_L2_TAIL);

   fc_mac_sat #(.ACC_W(ACC_W)) u_mac (
      .clk    (clk),
      .rst_n  (rst),
      .clr    (mac_clr),
      .acc_en (mac_en),
      .a      (mac_a),
      .b      (mac_b),
      .addend (mac_add),
      .sat_sum(mac_sat)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         j        <= '0;
         hid_idx  <= '0;
         i_cnt    <= '0;
         addr_q   <= '0;
         rd_vld   <= 1'b0;
         bias_q   <= '0;
         done     <= 1'b0;
         out_data <= '0;
         for (int k = 0; k < IP_LAYER; k++)
            hidden[k] <= '0;
      end else begin
         done   <= 1'b0;
         rd_vld <= in_rd_en | dw_rd_en;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bias_q <= bias;
                  j      <= '0;
                  i_cnt  <= I_RELOAD;
                  addr_q <= '0;
                  state  <= ST_L1;
               end
            end
            ST_L1: begin
               addr_q <= addr_q + AW'(1);
               if (i_cnt == '0)
                  state <= ST_L1_TAIL;
               else
                  i_cnt <= i_cnt - IW'(1);
            end
            ST_L1_TAIL: begin
               hidden[j] <= mac_sat;
               if (j == J_LAST) begin
                  j     <= '0;
                  state <= ST_L2;
               end else begin
                  j     <= j + JW'(1);
                  i_cnt <= I_RELOAD;
                  state <= ST_L1;
               end
            end
            ST_L2: begin
               hid_idx <= j;
               if (j == J_LAST) begin
                  j     <= '0;
                  state <= ST_L2_TAIL;
               end else begin
                  j <= j + JW'(1);
               end
            end
            ST_L2_TAIL: begin
               out_data <= mac_sat;
               done     <= 1'b1;
               state    <= ST_DONE;
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_seq.sv
// tb_fc_layer_seq: scoreboard bench for fc_layer_seq. Stimulus pushes the
// expected result and read-address trace; monitors pop and compare.
module tb_fc_layer_seq;

   localparam int IPL = 8;
   localparam int NI  = 8;
   localparam int LAT = IPL * (NI + 1) + IPL + 1;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               start = 1'b0;
   logic signed [15:0] bias = '0;
   logic               busy, done;
   logic signed [15:0] out_data;
   logic               in_rd_en, dw_rd_en;
   logic [5:0]         in_addr;
   logic [2:0]         dw_addr;
   logic signed [15:0] in_data = '0, wt_data = '0, dw_data = '0;

   fc_layer_seq #(.IP_LAYER(IPL), .NUM_INP(NI), .ACC_W(40)) dut (
      .clk(clk), .rst(rst), .start(start), .bias(bias),
      .busy(busy), .done(done), .out_data(out_data),
      .in_rd_en(in_rd_en), .in_addr(in_addr),
      .in_data(in_data), .wt_data(wt_data),
      .dw_rd_en(dw_rd_en), .dw_addr(dw_addr), .dw_data(dw_data)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   logic signed [15:0] in_mem [IPL*NI];
   logic signed [15:0] wt_mem [IPL*NI];
   logic signed [15:0] dw_mem [IPL];

   typedef struct {
      logic signed [15:0] val;
      int                 cyc;
   } exp_t;
   exp_t exp_q[$];
   int   in_q[$];
   int   dw_q[$];
   logic signed [15:0] last_out = '0;

   function automatic logic signed [15:0] sat16m(input longint v);
      if (v > 32767) return 16'sh7fff;
      if (v < -32768) return 16'sh8000;
      return 16'(v);
   endfunction

   // Reference: hidden[j] = sat(sum_i x*w); y = sat(sum_j hidden[j]*dw[j] + bias)
   task automatic push_expected(input logic signed [15:0] b, input int acc_cyc);
      longint h [IPL];
      longint s;
      for (int jj = 0; jj < IPL; jj++) begin
         s = 0;
         for (int ii = 0; ii < NI; ii++) begin
            s += longint'(in_mem[jj*NI+ii]) * longint'(wt_mem[jj*NI+ii]);
            in_q.push_back(jj * NI + ii);
         end
         h[jj] = longint'(sat16m(s));
      end
      s = longint'(b);
      for (int jj = 0; jj < IPL; jj++) begin
         s += h[jj] * longint'(dw_mem[jj]);
         dw_q.push_back(jj);
      end
      exp_q.push_back('{val: sat16m(s), cyc: acc_cyc + LAT});
   endtask

   task automatic fill_const(input int x, input int w, input int d);
      for (int k = 0; k < IPL*NI; k++) begin
         in_mem[k] = 16'(x);
         wt_mem[k] = 16'(w);
      end
      for (int k = 0; k < IPL; k++) dw_mem[k] = 16'(d);
   endtask

   task automatic fill_rand(input bit full);
      for (int k = 0; k < IPL*NI; k++) begin
         in_mem[k] = full ? 16'($urandom) : 16'(int'($urandom_range(400)) - 200);
         wt_mem[k] = full ? 16'($urandom) : 16'(int'($urandom_range(400)) - 200);
      end
      for (int k = 0; k < IPL; k++)
         dw_mem[k] = full ? 16'($urandom) : 16'(int'($urandom_range(60)) - 30);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge with the DUT expected idle this cycle.
   task automatic issue_start(input logic signed [15:0] b);
      start = 1'b1;
      bias  = b;
      push_expected(b, cyc + 1);
      step();
      start = 1'b0;
      bias  = 16'($urandom);
   endtask

   task automatic wait_done();
      for (int k = 0; k < LAT + 20; k++) begin
         if (done === 1'b1) return;
         step();
      end
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done_within_%0d", LAT + 20);
   endtask

   // Buffers: capture strobes between edges, present data the next cycle.
   initial begin
      logic       l_in, l_dw;
      logic [5:0] l_ia;
      logic [2:0] l_da;
      forever begin
         @(negedge clk);
         l_in = in_rd_en;
         l_ia = in_addr;
         l_dw = dw_rd_en;
         l_da = dw_addr;
         @(posedge clk);
         #1;
         in_data = l_in ? in_mem[l_ia] : 16'($urandom);
         wt_data = l_in ? wt_mem[l_ia] : 16'($urandom);
         dw_data = l_dw ? dw_mem[l_da] : 16'($urandom);
      end
   end

   // Monitor: read trace, strobe rules, done/result scoreboard.
   initial begin
      logic prev_done = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            check("strobe_overlap", in_rd_en & dw_rd_en, 0);
            check("strobe_while_idle", (in_rd_en | dw_rd_en) & ~busy, 0);
            if (in_rd_en) begin
               if (in_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL in_extra_read actual=addr%0d required=no_read", in_addr);
               end else
                  check("in_addr", in_addr, in_q.pop_front());
            end
            if (dw_rd_en) begin
               if (dw_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL dw_extra_read actual=addr%0d required=no_read", dw_addr);
               end else
                  check("dw_addr", dw_addr, dw_q.pop_front());
            end
            if (done === 1'b1) begin
               check("done_width", prev_done, 0);
               if (exp_q.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_done actual=done required=none out=%0d", out_data);
               end else begin
                  e = exp_q.pop_front();
                  last_out = e.val;
                  check("out_data", out_data, e.val);
                  check("done_cycle", cyc, e.cyc);
                  check("reads_pending", in_q.size() + dw_q.size(), 0);
               end
            end
            prev_done = done;
         end else begin
            prev_done = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic interfere();
      repeat (4) step();
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (34) step();
      check("out_hold", out_data, last_out);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) step();
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out", out_data, 0);
      check("rst_in_rd_en", in_rd_en, 0);
      check("rst_dw_rd_en", dw_rd_en, 0);
      check("rst_in_addr", in_addr, 0);
      check("rst_dw_addr", dw_addr, 0);
      rst = 1'b1;
      step();

      fill_const(1, 1, 1);
      issue_start(16'sd0);
      wait_done();
      check("ones_out", out_data, 64);
      step();
      check("idle_after_done", busy, 0);

      fill_const(1, 1, 2);
      issue_start(-16'sd5);
      wait_done();
      check("dw2_bias_out", out_data, 123);
      step();

      fill_const(100, 100, 1);
      issue_start(16'sd0);
      wait_done();
      check("sat_pos_out", out_data, 32767);
      step();

      fill_const(100, -100, 1);
      issue_start(16'sd0);
      wait_done();
      check("sat_neg_out", out_data, -32768);
      step();

      // Random transactions with ignored starts, start in DONE, back-to-back.
      fill_rand(1'b0);
      issue_start(16'($urandom));
      for (int t = 0; t < 5; t++) begin
         interfere();
         wait_done();
         start = 1'b1;
         bias  = 16'($urandom);
         fill_rand(t[0]);
         step();
         issue_start(16'($urandom));
      end
      interfere();
      wait_done();
      step();
      check("idle_after_b2b", busy, 0);

      // Reset mid-operation discards the result.
      fill_rand(1'b1);
      issue_start(16'($urandom));
      repeat (28) step();
      rst = 1'b0;
      #1;
      exp_q.delete();
      in_q.delete();
      dw_q.delete();
      last_out = '0;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_out", out_data, 0);
      check("midrst_in_rd_en", in_rd_en, 0);
      check("midrst_in_addr", in_addr, 0);
      repeat (3) step();
      rst = 1'b1;
      repeat (5) step();
      check("no_done_after_rst", done, 0);

      fill_const(3, 2, 1);
      issue_start(16'sd7);
      wait_done();
      check("post_rst_out", out_data, 391);

      repeat (5) step();
      check("scoreboard_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
